heat_grid_array: RTL and testbench
==================================

// Module: heat_grid_array
// PURPOSE
//  Parametrised 2-D explicit heat-diffusion engine: N_COLS column units, each holding N_ROWS nodes in local storage.
//  One start pulse runs one full Jacobi-equivalent sweep of the grid.
//  Updated rows stream out one row per cycle as a packed bus to the VGA/colour-map path.
//  Replaces the fixed 64-column grid with scalar outputs: adds configurable size/boundary, row streaming, iteration count, saturation.
// PARAMETERS
//  N_COLS   64  number of columns (grid width)
//  N_ROWS   64  nodes per column (grid height), >=2
//  DW       32  node/coefficient width, signed fixed point
//  FRAC     27  fractional bits (1 sign, DW-1-FRAC integer bits)
//  RAW      $clog2(N_ROWS)  row index width (localparam)
// PORTS
//  clk_50         in   1          system clock
//  reset          in   1          asynchronous, active-high reset
//  start          in   1          one-cycle pulse: begin one sweep (honoured only when ready=1)
//  coeff          in   DW         alpha*delta product, sampled on accepted start
//  boundary_val   in   DW         value of every out-of-grid neighbour, sampled on accepted start
//  ready          out  1          high in IDLE only
//  init_done      out  1          high once post-reset zero-fill is complete; stays high until reset
//  row_out        out  N_COLS*DW  updated row, column c at bits [c*DW +: DW]
//  row_out_idx    out  RAW        row index of row_out
//  row_out_valid  out  1          row_out/row_out_idx valid this cycle
//  flag           out  1          one-cycle pulse: sweep complete
//  iter_count     out  16         completed sweeps, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: FSM->INIT, row counter 0; ready, init_done, row_out, row_out_idx, row_out_valid, flag, iter_count = 0.
//  Reset is async: outputs clear in the same cycle it asserts, including mid-sweep; sweep is abandoned.
//  FSM INIT: writes 0 to row r of all columns, r=0..N_ROWS-1, one row/cycle -> IDLE; init_done, ready rise after exactly N_ROWS cycles.
//  IDLE: ready=1. start=1 -> latch coeff/boundary_val, ready=0 -> FILL. start in INIT/FILL/SWEEP/DONE is dropped, never queued.
//  FILL (2 cycles): load rows 0 and 1 into each column's 3-row window (prev/cur/next); prev = boundary_val.
//  SWEEP (N_ROWS cycles): each cycle computes row r for all columns in parallel.
//    Writes result in place at row r; old row r is kept as window prev.
//    Shifts window and fetches row r+2; rows beyond N_ROWS-1 read as boundary_val.
//  Per-node update:
//    up/down = window prev/next;
//    left/right = neighbour column cur, or boundary_val at col 0 / col N_COLS-1.
//  Arithmetic:
//    lap = up+down+left+right-4*c at DW+3 bits, no overflow;
//    p = (coeff*lap) >>> FRAC, full-precision product, arithmetic shift, truncation toward -inf;
//    new = c + p, saturated to [-2^(DW-1), 2^(DW-1)-1].
//  Streaming: the registered result of row r appears with row_out_valid=1, row_out_idx=r one cycle after its SWEEP cycle.
//    Rows stream in order 0..N_ROWS-1, contiguous, no gaps.
//  DONE (1 cycle, after last valid row): flag=1, iter_count+1 -> IDLE. Start-to-flag latency = N_ROWS+3 cycles.
//  row_out holds last value when row_out_valid=0.
// CONFIGURATION
//  HEAT_SRC_EN defined: adds inputs src_row(RAW), src_col($clog2(N_COLS)), src_val(DW), src_en(1), all sampled on accepted start.
//    If src_en latched: node (src_row,src_col) is written with src_val instead of its computed value every sweep (fixed hot spot).
//    Its neighbours see src_val from that row onward.
//    Out-of-range src_row/src_col: no forcing.
//  HEAT_SRC_EN undefined: these ports do not exist; every node follows the update rule.
// TESTING (bench N_COLS=4, N_ROWS=8, DW=32, FRAC=27)
//  1. Release reset -> init_done and ready rise exactly 8 cycles later.
//     start, boundary_val=0, coeff=0x00A3D70A -> 8 rows, all 0, idx 0..7; flag 11 cycles after start; iter_count=1.
//  2. boundary_val=0x08000000 (1.0), coeff=0x00A3D70A (0.08), one sweep from zeros ->
//     corners 0x0147AE14 (0.16); edge non-corners 0x00A3D70A; interior 0 (+-1 LSB).
//  3. boundary_val=0x7FFFFFFF, coeff=0x08000000 (1.0) -> corner and edge nodes = 0x7FFFFFFF (saturated, no wrap to negative).
//  4. start pulsed at SWEEP row 3 -> ignored; one flag pulse only; iter_count +1; ready stays 0 until IDLE.
//  5. reset asserted during SWEEP row 4 -> same-cycle outputs 0, iter_count=0; INIT reruns; next sweep with boundary 0 outputs all 0.
//  6. HEAT_SRC_EN, src_en=1, (2,1), src_val=0x08000000, boundary 0 ->
//     row_out_idx=2 col 1 = 0x08000000 every sweep; after sweep 1, (3,1) = 0x00A3D70A. Undefined: node follows the rule.

Source files
------------

// File: rtl/heat_grid_array.sv
// heat_grid_array: 2-D explicit heat-diffusion engine. Each start runs one Jacobi sweep and streams the rows out.
// Optional fixed hot-spot source: define HEAT_SRC_EN to add the src_* ports.
module heat_grid_array #(
  parameter int N_COLS = 64,
  parameter int N_ROWS = 64,
  parameter int DW     = 32,
  parameter int FRAC   = 27,
  localparam int RAW   = $clog2(N_ROWS),
  localparam int CAW   = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic                 clk_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DW-1:0]        coeff,
  input  logic [DW-1:0]        boundary_val,
`ifdef HEAT_SRC_EN
  input  logic [RAW-1:0]       src_row,
  input  logic [CAW-1:0]       src_col,
  input  logic [DW-1:0]        src_val,
  input  logic                 src_en,
`endif
  output logic                 ready,
  output logic                 init_done,
  output logic [N_COLS*DW-1:0] row_out,
  output logic [RAW-1:0]       row_out_idx,
  output logic                 row_out_valid,
  output logic                 flag,
  output logic [15:0]          iter_count
);

  localparam int LW = DW + 3;
  localparam int PW = DW + LW;
  localparam int SW = PW + 1;
  localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
  localparam logic [RAW-1:0] LAST_ROW = RAW'(N_ROWS - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_FILL, S_SWEEP, S_DONE} state_t;

  state_t               state;
  logic [RAW-1:0]       row_cnt;
  logic                 fill_phase;
  logic signed [DW-1:0] coeff_q;
  logic signed [DW-1:0] bnd_q;

  logic signed [DW-1:0] mem      [N_COLS][N_ROWS];
  logic signed [DW-1:0] win_prev [N_COLS];
  logic signed [DW-1:0] win_cur  [N_COLS];
  logic signed [DW-1:0] win_next [N_COLS];
  logic signed [DW-1:0] new_val  [N_COLS];
  logic signed [DW-1:0] keep_val [N_COLS];

  logic [RAW:0]   fetch_sum;
  logic           fetch_ok;
  logic [RAW-1:0] fetch_idx;

  assign fetch_sum = {1'b0, row_cnt} + (RAW+1)'(2);
  assign fetch_ok  = fetch_sum < (RAW+1)'(N_ROWS);
  assign fetch_idx = fetch_sum[RAW-1:0];

`ifdef HEAT_SRC_EN
  logic [RAW-1:0]       src_row_q;
  logic [CAW-1:0]       src_col_q;
  logic signed [DW-1:0] src_val_q;
  logic                 src_en_q;
  logic                 src_active;
  logic                 src_hit;

  // Out-of-range coordinates simply never match, so no node is forced.
  assign src_active = src_en_q
                      && ({1'b0, src_row_q} < (RAW+1)'(N_ROWS))
                      && ({1'b0, src_col_q} < (CAW+1)'(N_COLS));
  assign src_hit    = src_active && (row_cnt == src_row_q);
`endif

  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    logic signed [DW-1:0] left_v;
    logic signed [DW-1:0] right_v;
    logic signed [LW-1:0] lap;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] delta;
    logic signed [SW-1:0] sum;
    logic signed [DW-1:0] sat;

    if (c == 0) begin : g_left
      assign left_v = bnd_q;
    end else begin : g_left
      assign left_v = win_cur[c-1];
    end

    if (c == N_COLS - 1) begin : g_right
      assign right_v = bnd_q;
    end else begin : g_right
      assign right_v = win_cur[c+1];
    end

    // Widths are chosen so the Laplacian and the full product can never overflow.
    assign lap   = LW'(win_prev[c]) + LW'(win_next[c]) + LW'(left_v) + LW'(right_v)
                   - (LW'(win_cur[c]) <<< 2);
    assign prod  = PW'(coeff_q) * PW'(lap);
    assign delta = prod >>> FRAC;
    assign sum   = SW'(win_cur[c]) + SW'(delta);

    always_comb begin
      if (sum > SW'(MAXV)) begin
        sat = MAXV;
      end else if (sum < SW'(MINV)) begin
        sat = MINV;
      end else begin
        sat = sum[DW-1:0];
      end
    end

`ifdef HEAT_SRC_EN
    logic force_src;
    assign force_src   = src_hit && (src_col_q == CAW'(c));
    assign new_val[c]  = force_src ? src_val_q : sat;
    assign keep_val[c] = force_src ? src_val_q : win_cur[c];
`else
    assign new_val[c]  = sat;
    assign keep_val[c] = win_cur[c];
`endif
  end

  // Datapath: node storage and the per-column prev/cur/next window; old row r becomes prev (Jacobi).
  always_ff @(posedge clk_50) begin
    for (int c = 0; c < N_COLS; c++) begin
      case (state)
        S_INIT: mem[c][row_cnt] <= '0;
        S_FILL: begin
          if (!fill_phase) begin
            win_prev[c] <= bnd_q;
            win_cur[c]  <= mem[c][0];
          end else begin
            win_next[c] <= mem[c][1];
          end
        end
        S_SWEEP: begin
          mem[c][row_cnt] <= new_val[c];
          win_prev[c]     <= keep_val[c];
          win_cur[c]      <= win_next[c];
          win_next[c]     <= fetch_ok ? mem[c][fetch_idx] : bnd_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state         <= S_INIT;
      row_cnt       <= '0;
      fill_phase    <= 1'b0;
      coeff_q       <= '0;
      bnd_q         <= '0;
      ready         <= 1'b0;
      init_done     <= 1'b0;
      row_out       <= '0;
      row_out_idx   <= '0;
      row_out_valid <= 1'b0;
      flag          <= 1'b0;
      iter_count    <= '0;
`ifdef HEAT_SRC_EN
      src_row_q     <= '0;
      src_col_q     <= '0;
      src_val_q     <= '0;
      src_en_q      <= 1'b0;
`endif
    end else begin
      flag          <= 1'b0;
      row_out_valid <= 1'b0;
      case (state)
        S_INIT: begin
          if (row_cnt == LAST_ROW) begin
            row_cnt   <= '0;
            ready     <= 1'b1;
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            row_cnt <= row_cnt + RAW'(1);
          end
        end
        S_IDLE: begin
          if (start) begin
            coeff_q    <= coeff;
            bnd_q      <= boundary_val;
`ifdef HEAT_SRC_EN
            src_row_q  <= src_row;
            src_col_q  <= src_col;
            src_val_q  <= src_val;
            src_en_q   <= src_en;
`endif
            ready      <= 1'b0;
            fill_phase <= 1'b0;
            row_cnt    <= '0;
            state      <= S_FILL;
          end
        end
        S_FILL: begin
          if (fill_phase) begin
            fill_phase <= 1'b0;
            state      <= S_SWEEP;
          end else begin
            fill_phase <= 1'b1;
          end
        end
        S_SWEEP: begin
          row_out_valid <= 1'b1;
          row_out_idx   <= row_cnt;
          for (int c = 0; c < N_COLS; c++) begin
            row_out[c*DW +: DW] <= new_val[c];
          end
          if (row_cnt == LAST_ROW) begin
            row_cnt <= '0;
            state   <= S_DONE;
          end else begin
            row_cnt <= row_cnt + RAW'(1);
          end
        end
        S_DONE: begin
          flag       <= 1'b1;
          iter_count <= iter_count + 16'd1;
          ready      <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_heat_grid_array.sv
// tb_heat_grid_array: directed bench for heat_grid_array on a 4x8 grid, Q4.27 arithmetic.
// Source tests are compiled in when HEAT_SRC_EN is defined.
module tb_heat_grid_array;

  localparam int N_COLS = 4;
  localparam int N_ROWS = 8;
  localparam int DW     = 32;
  localparam int FRAC   = 27;

  localparam logic [31:0] K008  = 32'h00A3D70A;
  localparam logic [31:0] K016  = 32'h0147AE14;
  localparam logic [31:0] ONE   = 32'h08000000;
  localparam logic [31:0] MAXP  = 32'h7FFFFFFF;

  logic                 clk_50 = 1'b0;
  logic                 reset  = 1'b1;
  logic                 start  = 1'b0;
  logic [DW-1:0]        coeff  = '0;
  logic [DW-1:0]        boundary_val = '0;
`ifdef HEAT_SRC_EN
  logic [2:0]           src_row = '0;
  logic [1:0]           src_col = '0;
  logic [DW-1:0]        src_val = '0;
  logic                 src_en  = 1'b0;
`endif
  logic                 ready;
  logic                 init_done;
  logic [N_COLS*DW-1:0] row_out;
  logic [2:0]           row_out_idx;
  logic                 row_out_valid;
  logic                 flag;
  logic [15:0]          iter_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] cap [N_ROWS][N_COLS];
  int row_seen, order_err, flag_k, flag_cnt, ready_busy;

  heat_grid_array #(.N_COLS(N_COLS), .N_ROWS(N_ROWS), .DW(DW), .FRAC(FRAC)) dut (
    .clk_50       (clk_50),
    .reset        (reset),
    .start        (start),
    .coeff        (coeff),
    .boundary_val (boundary_val),
`ifdef HEAT_SRC_EN
    .src_row      (src_row),
    .src_col      (src_col),
    .src_val      (src_val),
    .src_en       (src_en),
`endif
    .ready        (ready),
    .init_done    (init_done),
    .row_out      (row_out),
    .row_out_idx  (row_out_idx),
    .row_out_valid(row_out_valid),
    .flag         (flag),
    .iter_count   (iter_count)
  );

  always #10 clk_50 = ~clk_50;

  // Number of grid edges a node touches; decides which hand-computed value applies.
  function automatic int edge_cnt(input int r, input int c);
    return int'(r == 0) + int'(r == N_ROWS-1) + int'(c == 0) + int'(c == N_COLS-1);
  endfunction

  // Releases reset at a negedge and counts rising edges until init_done appears (-1 if it never does).
  task automatic release_and_wait(output int cyc);
    reset = 1'b0;
    cyc = -1;
    for (int t = 1; t <= 30 && cyc < 0; t++) begin
      @(negedge clk_50);
      if (init_done === 1'b1) cyc = t;
    end
  endtask

  task automatic pulse_reset();
    int cyc;
    @(negedge clk_50);
    reset = 1'b1;
    @(negedge clk_50);
    release_and_wait(cyc);
  endtask

  // Pulses start, then watches 20 cycles capturing rows and flags; optional extra start at cycle poke_k.
  task automatic run_sweep(input logic [31:0] k, input logic [31:0] b, input int poke_k);
    @(negedge clk_50);
    coeff = k;
    boundary_val = b;
    start = 1'b1;
    @(negedge clk_50);
    start = 1'b0;
    row_seen = 0; order_err = 0; flag_k = -1; flag_cnt = 0; ready_busy = 0;
    for (int t = 1; t <= 20; t++) begin
      if (row_out_valid === 1'b1) begin
        if (row_out_idx !== 3'(row_seen)) order_err++;
        for (int c = 0; c < N_COLS; c++) cap[row_out_idx][c] = row_out[c*DW +: DW];
        row_seen++;
      end
      if (flag === 1'b1) begin
        flag_cnt++;
        if (flag_k < 0) flag_k = t - 1;
      end
      if (ready === 1'b1 && flag_k < 0) ready_busy++;
      start = (t == poke_k);
      @(negedge clk_50);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    reset = 1'b1;
    repeat (2) @(negedge clk_50);
    checks++;
    if ({ready, init_done, row_out_valid, flag} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 0000", {ready, init_done, row_out_valid, flag});
    end
    checks++;
    if (iter_count !== 16'd0 || row_out !== '0 || row_out_idx !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: iter=%0d idx=%0d row=%h, expected all 0", iter_count, row_out_idx, row_out);
    end
    release_and_wait(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("[TB] FAIL init_latency: got %0d cycles, expected 8", cyc);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_init: got %b, expected 1", ready);
    end
  endtask

  task automatic test_zero_sweep();
    run_sweep(K008, 32'h0, 0);
    checks++;
    if (row_seen !== 8 || order_err !== 0) begin
      errors++;
      $display("[TB] FAIL zero_rows: got %0d rows, %0d order errors, expected 8 and 0", row_seen, order_err);
    end
    checks++;
    if (flag_k !== 11 || flag_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL zero_flag: got latency %0d count %0d, expected 11 and 1", flag_k, flag_cnt);
    end
    checks++;
    if (iter_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL zero_iter: got %0d, expected 1", iter_count);
    end
    for (int r = 0; r < N_ROWS; r++)
      for (int c = 0; c < N_COLS; c++) begin
        checks++;
        if (cap[r][c] !== 32'h0) begin
          errors++;
          $display("[TB] FAIL zero_node r%0d c%0d: got %h, expected 00000000", r, c, cap[r][c]);
        end
      end
  endtask

  task automatic test_boundary();
    logic [31:0] exp_v;
    run_sweep(K008, ONE, 0);
    for (int r = 0; r < N_ROWS; r++)
      for (int c = 0; c < N_COLS; c++) begin
        case (edge_cnt(r, c))
          2:       exp_v = K016;
          1:       exp_v = K008;
          default: exp_v = 32'h0;
        endcase
        checks++;
        if (cap[r][c] !== exp_v) begin
          errors++;
          $display("[TB] FAIL bnd_node r%0d c%0d: got %h, expected %h", r, c, cap[r][c], exp_v);
        end
      end
    checks++;
    if (iter_count !== 16'd2 || flag_k !== 11) begin
      errors++;
      $display("[TB] FAIL bnd_iter: got iter %0d latency %0d, expected 2 and 11", iter_count, flag_k);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] exp_v;
    pulse_reset();
    run_sweep(ONE, MAXP, 0);
    for (int r = 0; r < N_ROWS; r++)
      for (int c = 0; c < N_COLS; c++) begin
        exp_v = (edge_cnt(r, c) > 0) ? MAXP : 32'h0;
        checks++;
        if (cap[r][c] !== exp_v) begin
          errors++;
          $display("[TB] FAIL sat_node r%0d c%0d: got %h, expected %h", r, c, cap[r][c], exp_v);
        end
      end
    checks++;
    if (iter_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL sat_iter: got %0d, expected 1", iter_count);
    end
  endtask

  task automatic test_start_ignored();
    run_sweep(K008, 32'h0, 6);
    checks++;
    if (flag_cnt !== 1 || flag_k !== 11) begin
      errors++;
      $display("[TB] FAIL busy_flag: got count %0d latency %0d, expected 1 and 11", flag_cnt, flag_k);
    end
    checks++;
    if (iter_count !== 16'd2) begin
      errors++;
      $display("[TB] FAIL busy_iter: got %0d, expected 2", iter_count);
    end
    checks++;
    if (ready_busy !== 0 || ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_ready: got %0d early-ready cycles, ready=%b, expected 0 and 1", ready_busy, ready);
    end
    checks++;
    if (row_seen !== 8 || order_err !== 0) begin
      errors++;
      $display("[TB] FAIL busy_rows: got %0d rows, %0d order errors, expected 8 and 0", row_seen, order_err);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    @(negedge clk_50);
    coeff = K008;
    boundary_val = ONE;
    start = 1'b1;
    @(negedge clk_50);
    start = 1'b0;
    repeat (6) @(negedge clk_50);
    checks++;
    if (row_out_valid !== 1'b1 || row_out_idx !== 3'd3) begin
      errors++;
      $display("[TB] FAIL mid_pre: got valid %b idx %0d, expected 1 and 3", row_out_valid, row_out_idx);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ready, init_done, row_out_valid, flag} !== 4'b0000 || iter_count !== 16'd0 || row_out !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got ctrl %b iter %0d row %h, expected all 0",
               {ready, init_done, row_out_valid, flag}, iter_count, row_out);
    end
    @(negedge clk_50);
    release_and_wait(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("[TB] FAIL mid_reinit: got %0d cycles, expected 8", cyc);
    end
    run_sweep(K008, 32'h0, 0);
    for (int r = 0; r < N_ROWS; r++) begin
      checks++;
      if (cap[r][0] !== 32'h0 || cap[r][1] !== 32'h0 || cap[r][2] !== 32'h0 || cap[r][3] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL mid_row%0d: got %h %h %h %h, expected all 0", r, cap[r][0], cap[r][1], cap[r][2], cap[r][3]);
      end
    end
    checks++;
    if (iter_count !== 16'd1 || row_seen !== 8) begin
      errors++;
      $display("[TB] FAIL mid_iter: got iter %0d rows %0d, expected 1 and 8", iter_count, row_seen);
    end
  endtask

`ifdef HEAT_SRC_EN
  task automatic test_source();
    pulse_reset();
    src_row = 3'd2;
    src_col = 2'd1;
    src_val = ONE;
    src_en  = 1'b1;
    run_sweep(K008, 32'h0, 0);
    checks++;
    if (cap[2][1] !== ONE) begin
      errors++;
      $display("[TB] FAIL src1_hot: got %h, expected %h", cap[2][1], ONE);
    end
    checks++;
    if (cap[3][1] !== K008) begin
      errors++;
      $display("[TB] FAIL src1_below: got %h, expected %h", cap[3][1], K008);
    end
    checks++;
    if (cap[1][1] !== 32'h0 || cap[2][0] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL src1_old: got %h %h, expected 0 0", cap[1][1], cap[2][0]);
    end
    run_sweep(K008, 32'h0, 0);
    checks++;
    if (cap[2][1] !== ONE) begin
      errors++;
      $display("[TB] FAIL src2_hot: got %h, expected %h", cap[2][1], ONE);
    end
    checks++;
    if (cap[1][1] !== K008 || cap[2][0] !== K008) begin
      errors++;
      $display("[TB] FAIL src2_nbr: got %h %h, expected %h %h", cap[1][1], cap[2][0], K008, K008);
    end
    src_en = 1'b0;
  endtask
`else
  task automatic test_source();
    run_sweep(K008, ONE, 0);
    checks++;
    if (cap[2][1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL nosrc_interior: got %h, expected 00000000", cap[2][1]);
    end
    checks++;
    if (cap[2][0] !== K008) begin
      errors++;
      $display("[TB] FAIL nosrc_edge: got %h, expected %h", cap[2][0], K008);
    end
  endtask
`endif

  initial begin
    $display("[TB] heat_grid_array directed bench start");
    test_reset();
    test_zero_sweep();
    test_boundary();
    test_saturation();
    test_start_ignored();
    test_reset_mid_sweep();
    test_source();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
